// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared constants for the parametrised up/down counter family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    // Direction encoding on the inc input
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Bound behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/udcnt_next.sv
// ============================================================================
// Module : udcnt_next
// Brief  : Combinational next-count and bound-detect for the up/down counter.
//          Produces the value the counter would take on a count step and flags
//          when that step starts at the bound in the count direction.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module udcnt_next
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    output logic [WIDTH-1:0] next,
    output logic             at_bound
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Step one position in the selected direction, wrapping or holding at bounds
    always_comb begin
        next     = cur;
        at_bound = 1'b0;
        if (inc == DIR_UP) begin
            // >= rather than == so an out-of-range value can never step upward
            if (cur >= MAX_VAL) begin
                at_bound = 1'b1;
                next     = (SATURATE == MODE_SAT) ? MAX_VAL : c_zero;
            end else begin
                next     = cur + c_one;
            end
        end else begin
            if (cur == c_zero) begin
                at_bound = 1'b1;
                next     = (SATURATE == MODE_SAT) ? c_zero : MAX_VAL;
            end else begin
                next     = cur - c_one;
            end
        end
    end

endmodule : udcnt_next

`default_nettype wire

// File: rtl/updown_counter_param.sv
// ============================================================================
// Module : updown_counter_param
// Brief  : WIDTH-bit up/down counter with programmable modulus (0..MAX_VAL),
//          wrap or saturate at bounds, registered terminal-count pulse and a
//          sticky overflow flag. Cascade by feeding tc into the next stage's
//          countEN.
//          Optional macro UDCNT_MATCH_EN adds match_val/match: a registered
//          compare that is high in the same cycle out equals match_val.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module updown_counter_param
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter int               SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             countEN,
    input  logic             inc,
    input  logic [WIDTH-1:0] data_in,
`ifdef UDCNT_MATCH_EN
    input  logic [WIDTH-1:0] match_val,
    output logic             match,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_step;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_out_d;
    logic             w_tc_d;
    logic             w_ovf_d;

    udcnt_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .cur      (r_out),
        .inc      (inc),
        .next     (w_step),
        .at_bound (w_at_bound)
    );

    // Load values above the modulus clamp to MAX_VAL so out never leaves range
    assign w_load_val = (data_in > MAX_VAL) ? MAX_VAL : data_in;

    // Priority select: clear > load > count > hold
    always_comb begin
        w_out_d = r_out;
        w_tc_d  = 1'b0;
        w_ovf_d = r_ovf;
        if (clear) begin
            w_out_d = '0;
            w_ovf_d = 1'b0;
        end else if (load) begin
            w_out_d = w_load_val;
        end else if (countEN) begin
            w_out_d = w_step;
            w_tc_d  = w_at_bound;
            w_ovf_d = r_ovf | w_at_bound;
        end
    end

    // Counter state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_out <= w_out_d;
            r_tc  <= w_tc_d;
            r_ovf <= w_ovf_d;
        end
    end

    assign out = r_out;
    assign tc  = r_tc;
    assign ovf = r_ovf;

`ifdef UDCNT_MATCH_EN
    logic r_match;

    // Compare against the value out is about to take so match lines up with out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else if (clear) begin
            r_match <= 1'b0;
        end else begin
            r_match <= (w_out_d == match_val);
        end
    end

    assign match = r_match;
`endif

endmodule : updown_counter_param

`default_nettype wire

// File: tb/tb_updown_counter_param.sv
// ============================================================================
// Module : tb_updown_counter_param
// Brief  : Directed bench for updown_counter_param. Three instances share the
//          stimulus: MAX_VAL=9 wrap, MAX_VAL=9 saturate, full-range wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_param;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic       countEN;
    logic       inc;
    logic [7:0] data_in;
    logic [7:0] match_val;

    logic [7:0] w_out;
    logic       w_tc;
    logic       w_ovf;
    logic [7:0] s_out;
    logic       s_tc;
    logic       s_ovf;
    logic [7:0] f_out;
    logic       f_tc;
    logic       f_ovf;
    logic       w_match;
    logic       s_match;
    logic       f_match;

    int err_cnt = 0;
    int chk_cnt = 0;

    updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .countEN(countEN),
        .inc(inc), .data_in(data_in),
`ifdef UDCNT_MATCH_EN
        .match_val(match_val), .match(w_match),
`endif
        .out(w_out), .tc(w_tc), .ovf(w_ovf)
    );

    updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .countEN(countEN),
        .inc(inc), .data_in(data_in),
`ifdef UDCNT_MATCH_EN
        .match_val(match_val), .match(s_match),
`endif
        .out(s_out), .tc(s_tc), .ovf(s_ovf)
    );

    updown_counter_param #(.WIDTH(8)) u_full (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .countEN(countEN),
        .inc(inc), .data_in(data_in),
`ifdef UDCNT_MATCH_EN
        .match_val(match_val), .match(f_match),
`endif
        .out(f_out), .tc(f_tc), .ovf(f_ovf)
    );

`ifndef UDCNT_MATCH_EN
    assign w_match = 1'b0;
    assign s_match = 1'b0;
    assign f_match = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare all three instances: (out, tc, ovf) for wrap, sat, full
    task automatic expect_all(input string tag,
                              input int wo, input int wt, input int wv,
                              input int so, input int st, input int sv,
                              input int fo, input int ft, input int fv);
        check({tag, ".wrap.out"}, 32'(w_out), 32'(wo));
        check({tag, ".wrap.tc"},  32'(w_tc),  32'(wt));
        check({tag, ".wrap.ovf"}, 32'(w_ovf), 32'(wv));
        check({tag, ".sat.out"},  32'(s_out), 32'(so));
        check({tag, ".sat.tc"},   32'(s_tc),  32'(st));
        check({tag, ".sat.ovf"},  32'(s_ovf), 32'(sv));
        check({tag, ".full.out"}, 32'(f_out), 32'(fo));
        check({tag, ".full.tc"},  32'(f_tc),  32'(ft));
        check({tag, ".full.ovf"}, 32'(f_ovf), 32'(fv));
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic i,
                         input logic [7:0] d);
        clear   = c;
        load    = l;
        countEN = e;
        inc     = i;
        data_in = d;
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        match_val = 8'd4;
        drive(0, 0, 0, 1, 8'd0);
        #1 rst_n = 1'b0;
        #1;
        expect_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // Load 37: MAX_VAL=9 instances clamp
        drive(0, 1, 0, 1, 8'd37);
        tick();
        expect_all("load37", 9, 0, 0, 9, 0, 0, 37, 0, 0);
        drive(0, 0, 1, 1, 8'd0);
        tick();
        expect_all("up_from9", 0, 1, 1, 9, 1, 1, 38, 0, 0);

        // Asynchronous reset mid-cycle, checked before the next edge
        drive(0, 0, 1, 1, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        expect_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // Wrap upward from 7
        drive(0, 1, 0, 1, 8'd7);
        tick();
        expect_all("load7", 7, 0, 0, 7, 0, 0, 7, 0, 0);
        drive(0, 0, 1, 1, 8'd0);
        tick();
        expect_all("up1", 8, 0, 0, 8, 0, 0, 8, 0, 0);
        tick();
        expect_all("up2", 9, 0, 0, 9, 0, 0, 9, 0, 0);
        tick();
        expect_all("up3", 0, 1, 1, 9, 1, 1, 10, 0, 0);
        drive(0, 0, 0, 1, 8'd0);
        tick();
        expect_all("hold", 0, 0, 1, 9, 0, 1, 10, 0, 0);

        // Clear, then wrap downward from 1
        drive(1, 0, 0, 0, 8'd0);
        tick();
        expect_all("clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 8'd1);
        tick();
        expect_all("load1", 1, 0, 0, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 8'd0);
        tick();
        expect_all("dn1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_all("dn2", 9, 1, 1, 0, 1, 1, 255, 1, 1);

        // Saturate at the top, then step back down
        drive(0, 1, 0, 1, 8'd9);
        tick();
        expect_all("load9", 9, 0, 1, 9, 0, 1, 9, 0, 1);
        drive(0, 0, 1, 1, 8'd0);
        tick();
        expect_all("sat_up1", 0, 1, 1, 9, 1, 1, 10, 0, 1);
        tick();
        expect_all("sat_up2", 1, 0, 1, 9, 1, 1, 11, 0, 1);
        drive(0, 0, 1, 0, 8'd0);
        tick();
        expect_all("sat_dn", 0, 0, 1, 8, 0, 1, 10, 0, 1);

        // Priority: clear beats load and count; load beats count and clamps
        drive(0, 1, 0, 1, 8'd5);
        tick();
        expect_all("load5", 5, 0, 1, 5, 0, 1, 5, 0, 1);
        drive(1, 1, 1, 1, 8'd200);
        tick();
        expect_all("clr_prio", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 8'd200);
        tick();
        expect_all("load_prio", 9, 0, 0, 9, 0, 0, 200, 0, 0);
        drive(0, 0, 1, 1, 8'd0);
        tick();
        expect_all("bound_up", 0, 1, 1, 9, 1, 1, 201, 0, 0);
        // Load leaves the sticky flag alone
        drive(0, 1, 1, 0, 8'd3);
        tick();
        expect_all("load_keep_ovf", 3, 0, 1, 3, 0, 1, 3, 0, 0);

`ifdef UDCNT_MATCH_EN
        // Compare against match_val=4 while counting up from 2
        drive(0, 1, 0, 1, 8'd2);
        tick();
        check("match.load2", 32'(w_match), 32'd0);
        drive(0, 0, 1, 1, 8'd0);
        tick();
        check("match.out3", 32'(w_match), 32'd0);
        tick();
        check("match.out4", 32'(w_match), 32'd1);
        check("match.full4", 32'(f_match), 32'd1);
        tick();
        check("match.out5", 32'(w_match), 32'd0);
        drive(1, 0, 0, 1, 8'd0);
        tick();
        check("match.clear", 32'(s_match), 32'd0);
`else
        check("nomatch.tie", 32'(w_match | s_match | f_match), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_updown_counter_param

`default_nettype wire
